sd_demux2: RTL and testbench



---
 rtl/sd_mux_pkg.sv | 16 +
 rtl/sd_demux2.sv | 88 ++++++++
 tb/tb_sd_demux2.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/sd_mux_pkg.sv
// Shared phase naming for both ends of the sd_enmux2 -> sd_demux2 narrow link.
package sd_mux_pkg;

  // Receiver phase: which half of the token the next accepted transfer carries.
  typedef enum logic {
    s_upper = 1'b0,
    s_lower = 1'b1
  } demux_state_e;

  // Sender phase, kept here so the two ends agree on what "upper first" means.
  typedef enum logic {
    e_upper = 1'b0,
    e_lower = 1'b1
  } enmux_state_e;

endpackage

// File: rtl/sd_demux2.sv
// 2:1 srdy/drdy demultiplexer: joins upper/lower half-tokens into one full token
// held in a registered output stage.
module sd_demux2
  import sd_mux_pkg::*;
#(
  parameter int width = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c_srdy,
  output logic               c_drdy,
  input  logic [width/2-1:0] c_data,
  output logic               p_srdy,
  input  logic               p_drdy,
  output logic [width-1:0]   p_data
);

  localparam int HW = width / 2;

  demux_state_e   state_q, state_d;
  logic           p_srdy_q, p_srdy_d;
  logic [HW-1:0]  upper_q, upper_d;
  logic [width-1:0] p_data_q, p_data_d;
  logic           ready;
  logic           load;

  always_comb begin
    state_d  = state_q;
    upper_d  = upper_q;
    p_srdy_d = p_srdy_q;
    p_data_d = p_data_q;
    ready    = 1'b1;
    load     = 1'b0;

    case (state_q)
      s_upper: begin
        // upper_hold is independent of the output register, so never stall here
        ready = 1'b1;
        if (c_srdy) begin
          upper_d = c_data;
          state_d = s_lower;
        end
      end
      s_lower: begin
        ready = !p_srdy_q || p_drdy;
        if (c_srdy && ready) begin
          load    = 1'b1;
          state_d = s_upper;
        end
      end
      default: begin
        state_d = s_upper;
      end
    endcase

    if (load) begin
      p_srdy_d = 1'b1;
      p_data_d = {upper_q, c_data};
    end else if (p_srdy_q && p_drdy) begin
      p_srdy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= s_upper;
      p_srdy_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      p_srdy_q <= p_srdy_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      upper_q  <= '0;
      p_data_q <= '0;
    end else begin
      upper_q  <= upper_d;
      p_data_q <= p_data_d;
    end
  end

  assign c_drdy = ready;
  assign p_srdy = p_srdy_q;
  assign p_data = p_data_q;

endmodule

// File: tb/tb_sd_demux2.sv
// Scoreboard bench for sd_demux2: stimulus pushes expected tokens, a negedge
// monitor pops and compares on every output transfer.
module tb_sd_demux2;
  import sd_mux_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       c_srdy;
  logic       c_drdy;
  logic [3:0] c_data;
  logic       p_srdy;
  logic       p_drdy;
  logic [7:0] p_data;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  bit rand_drdy = 1'b0;

  sd_demux2 #(.width(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .c_srdy (c_srdy),
    .c_drdy (c_drdy),
    .c_data (c_data),
    .p_srdy (p_srdy),
    .p_drdy (p_drdy),
    .p_data (p_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Monitor: values at the negedge are what the next rising edge transfers.
  always @(negedge clk) begin
    if (!reset && p_srdy && p_drdy) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_token", {24'd0, p_data}, 32'hFFFF_FFFF);
      end else begin
        chk("token", {24'd0, p_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  always @(posedge clk) begin
    if (rand_drdy) begin
      #1 p_drdy = 1'($urandom_range(0, 1));
    end
  end

  // Offers one half-token; optionally requires acceptance in the first cycle.
  task automatic send_half(input logic [3:0] d, input bit must_be_ready);
    int n = 0;
    c_srdy = 1'b1;
    c_data = d;
    @(negedge clk);
    while (!c_drdy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!c_drdy) chk("accept_timeout", 32'd0, 32'd1);
    if (must_be_ready) chk("c_drdy_high", {31'd0, c_drdy}, 32'd1);
    @(posedge clk);
    #1;
    c_srdy = 1'b0;
  endtask

  task automatic send_pair(input logic [3:0] up, input logic [3:0] lo,
                           input logic [7:0] tok, input bit must_be_ready);
    send_half(up, must_be_ready);
    exp_q.push_back(tok);
    send_half(lo, must_be_ready);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain;
    int n = 0;
    p_drdy = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    c_srdy = 1'b0;
    c_data = '0;
    p_drdy = 1'b1;
    #2;
    chk("rst_p_srdy", {31'd0, p_srdy}, 32'd0);
    chk("rst_p_data", {24'd0, p_data}, 32'd0);
    chk("rst_c_drdy", {31'd0, c_drdy}, 32'd1);
    idle(2);
    reset = 1'b0;
    chk("post_rst_c_drdy", {31'd0, c_drdy}, 32'd1);

    // Basic pair and one-cycle latency
    send_half(4'hA, 1'b1);
    exp_q.push_back(8'hA5);
    send_half(4'h5, 1'b1);
    chk("latency_p_srdy", {31'd0, p_srdy}, 32'd1);
    chk("latency_p_data", {24'd0, p_data}, 32'hA5);
    idle(2);

    // Streaming with no gaps; every half must be accepted on first offer
    send_pair(4'hA, 4'h5, 8'hA5, 1'b1);
    send_pair(4'h3, 4'hC, 8'h3C, 1'b1);
    send_pair(4'hF, 4'h0, 8'hF0, 1'b1);
    idle(2);

    // Backpressure: full output, upper still accepted, lower stalls
    p_drdy = 1'b0;
    send_pair(4'hA, 4'h5, 8'hA5, 1'b1);
    send_half(4'h1, 1'b1);
    c_srdy = 1'b1;
    c_data = 4'h2;
    exp_q.push_back(8'h12);
    repeat (3) begin
      @(negedge clk);
      chk("bp_c_drdy_low", {31'd0, c_drdy}, 32'd0);
      chk("bp_hold_data", {24'd0, p_data}, 32'hA5);
    end
    @(posedge clk);
    #1;
    p_drdy = 1'b1;
    @(negedge clk);
    chk("bp_release_c_drdy", {31'd0, c_drdy}, 32'd1);
    @(posedge clk);
    #1;
    c_srdy = 1'b0;
    chk("bp_swap_p_srdy", {31'd0, p_srdy}, 32'd1);
    chk("bp_swap_p_data", {24'd0, p_data}, 32'h12);
    drain();

    // Reset mid-stream with a held token and a held upper half
    p_drdy = 1'b0;
    send_pair(4'h6, 4'h9, 8'h69, 1'b1);
    send_half(4'hB, 1'b1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_p_srdy", {31'd0, p_srdy}, 32'd0);
    chk("midrst_p_data", {24'd0, p_data}, 32'd0);
    chk("midrst_c_drdy", {31'd0, c_drdy}, 32'd1);
    idle(2);
    reset = 1'b0;
    p_drdy = 1'b1;
    send_pair(4'hA, 4'h5, 8'hA5, 1'b1);
    idle(1);

    // Reset mid-pair: upper 0x7 must be discarded
    send_half(4'h7, 1'b1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    send_pair(4'h3, 4'h4, 8'h34, 1'b1);
    drain();

    // Gaps between halves and random consumer stalls
    rand_drdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [3:0] up;
      logic [3:0] lo;
      up = 4'($urandom_range(0, 15));
      lo = 4'($urandom_range(0, 15));
      send_half(up, 1'b0);
      idle(int'($urandom_range(0, 3)));
      exp_q.push_back({up, lo});
      send_half(lo, 1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    rand_drdy = 1'b0;
    idle(1);
    drain();
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
